axi_rd_arb: RTL and testbench

Parametrised AXI3 read-channel arbiter and line assembler serving NUM_REQ cache/uncache requesters (icache, dcache, uncache and any added later). Grants one requester at a time round-robin, issues a single INCR burst of per-request length, packs returned beats into a line buffer and pulses the requester's reload. Sits between the cache blocks and the AXI master ports in the CPU top, replacing the fixed three-client read path of the current AXI controller.

---
 rtl/axi_rd_arb_pkg.sv | 8 +
 rtl/axi_rd_arb_rr_arbiter.sv | 22 ++
 rtl/axi_rd_arb.sv | 121 ++++++++++++
 tb/tb_axi_rd_arb.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/axi_rd_arb_pkg.sv
// axi_rd_arb_pkg: shared AXI3 constants and the read-arbiter FSM state encoding.
// No ports. Exports BURST_INCR, SIZE_WORD, RESP_OKAY and state_t.
package axi_rd_arb_pkg;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;
endpackage

// File: rtl/axi_rd_arb_rr_arbiter.sv
// axi_rd_arb_rr_arbiter: combinational round-robin pick starting at ptr.
// Ports: req (request vector), ptr (highest-priority index),
//        gnt (one-hot winner), idx (winner index), any (some request pending).
module axi_rd_arb_rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);
    // Walk from the farthest offset back to ptr so the closest requester wins.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[(int'(ptr) + i) % N]) idx = PW'((int'(ptr) + i) % N);
    end
    assign any = |req;
    assign gnt = any ? N'(1) << idx : '0;
endmodule

// File: rtl/axi_rd_arb.sv
// axi_rd_arb: round-robin AXI3 read arbiter and line assembler for NUM_REQ requesters.
// Ports: clk/resetn (sync, active-low); req/req_addr/req_len per requester;
//        reload (completion pulse), line_data (assembled beats), rd_err;
//        AXI3 AR channel (arid..arvalid, arready) and R channel (rid..rvalid, rready).
module axi_rd_arb
    import axi_rd_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int LINE_BEATS = 16
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*32-1:0]     req_addr,
    input  logic [NUM_REQ*4-1:0]      req_len,
    output logic [NUM_REQ-1:0]        reload,
    output logic [LINE_BEATS*32-1:0]  line_data,
    output logic                      rd_err,
    output logic [3:0]                arid,
    output logic [31:0]               araddr,
    output logic [3:0]                arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    output logic [1:0]                arlock,
    output logic [3:0]                arcache,
    output logic [2:0]                arprot,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [3:0]                rid,
    input  logic [31:0]               rdata,
    input  logic [1:0]                rresp,
    input  logic                      rlast,
    input  logic                      rvalid,
    output logic                      rready
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int LW = $clog2(LINE_BEATS);

    state_t             state;
    logic [PW-1:0]      grant, ptr, win;
    logic [NUM_REQ-1:0] win_oh, sel;
    logic               any, err, beat, beat_err;
    logic [4:0]         cnt;
    logic [31:0]        line [LINE_BEATS];

    axi_rd_arb_rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
        .req(req), .ptr(ptr), .gnt(win_oh), .idx(win), .any(any)
    );

    assign arsize  = SIZE_WORD;
    assign arburst = BURST_INCR;
    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;

    // Beats for other ids are still handshaken (rready high) but ignored here.
    assign beat = state == R && rvalid && rid == 4'(grant);
    // arlen holds the latched burst length for the whole transaction.
    assign beat_err = rresp != RESP_OKAY || cnt >= 5'(LINE_BEATS) ||
                      (rlast ? cnt != {1'b0, arlen} : cnt > {1'b0, arlen});

    for (genvar k = 0; k < LINE_BEATS; k++) begin : g_line
        assign line_data[32*k +: 32] = line[k];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            grant   <= '0;
            sel     <= '0;
            ptr     <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            reload  <= '0;
            rd_err  <= 1'b0;
            araddr  <= '0;
            arlen   <= '0;
            arid    <= '0;
            for (int k = 0; k < LINE_BEATS; k++) line[k] <= '0;
        end else begin
            case (state)
                IDLE: if (any) begin
                    grant   <= win;
                    sel     <= win_oh;
                    araddr  <= req_addr[32*int'(win) +: 32];
                    arlen   <= req_len[4*int'(win) +: 4];
                    arid    <= 4'(win);
                    cnt     <= '0;
                    err     <= 1'b0;
                    arvalid <= 1'b1;
                    state   <= AR;
                    for (int k = 0; k < LINE_BEATS; k++) line[k] <= '0;
                end
                AR: if (arready) begin
                    arvalid <= 1'b0;
                    rready  <= 1'b1;
                    state   <= R;
                end
                R: if (beat) begin
                    if (cnt < 5'(LINE_BEATS)) line[cnt[LW-1:0]] <= rdata;
                    cnt <= cnt + 5'd1;
                    err <= err | beat_err;
                    if (rlast) begin
                        rready <= 1'b0;
                        reload <= sel;
                        rd_err <= err | beat_err;
                        state  <= DONE;
                    end
                end
                default: begin
                    reload <= '0;
                    rd_err <= 1'b0;
                    ptr    <= grant == PW'(NUM_REQ - 1) ? '0 : grant + 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_rd_arb.sv
// tb_axi_rd_arb: randomized directed-sequence bench for axi_rd_arb against a transaction-level model.
module tb_axi_rd_arb;
    localparam int N  = 3;
    localparam int LB = 16;

    logic              clk = 1'b0, resetn = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N*32-1:0]   req_addr = '0;
    logic [N*4-1:0]    req_len = '0;
    logic [N-1:0]      reload;
    logic [LB*32-1:0]  line_data;
    logic              rd_err;
    logic [3:0]        arid, arlen, arcache;
    logic [31:0]       araddr;
    logic [2:0]        arsize, arprot;
    logic [1:0]        arburst, arlock;
    logic              arvalid, rready;
    logic              arready = 1'b0;
    logic [3:0]        rid = '0;
    logic [31:0]       rdata = '0;
    logic [1:0]        rresp = '0;
    logic              rlast = 1'b0, rvalid = 1'b0;

    int passed = 0, total = 0, m_ptr = 0;

    axi_rd_arb #(.NUM_REQ(N), .LINE_BEATS(LB)) dut (
        .clk(clk), .resetn(resetn), .req(req), .req_addr(req_addr), .req_len(req_len),
        .reload(reload), .line_data(line_data), .rd_err(rd_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        req = '0;
        @(negedge clk);
        resetn = 1'b1;
        m_ptr = 0;
    endtask

    // One read transaction as seen by the requesters and an AXI slave model.
    // Winner: first requester in mask at or after the model pointer.
    // Error: bad rresp, rlast position differing from len, or more beats than the line holds.
    task automatic txn(input logic [N-1:0] mask, input logic [3:0] len, input int nbeats,
                       input int bad, input int dmode, input bit keep, input int abort);
        int w;
        logic [511:0] exp_line;
        bit exp_err;
        logic [31:0] d, a;
        w = m_ptr;
        while (!mask[w]) w = (w + 1) % N;
        for (int i = 0; i < N; i++) begin
            req_addr[32*i +: 32] = $urandom;
            req_len[4*i +: 4] = 4'($urandom);
        end
        req_len[4*w +: 4] = len;
        if (dmode == 2) req_addr[32*w +: 32] = 32'hBFAF_8000;
        a = req_addr[32*w +: 32];
        req = mask;
        @(negedge clk);
        chk("arvalid", arvalid, 1'b1);
        chk("arid", arid, 4'(w));
        chk("araddr", araddr, a);
        chk("arlen", arlen, len);
        chk("ar_const", {arsize, arburst, arlock, arcache, arprot}, {3'b010, 2'b01, 2'b00, 4'h0, 3'h0});
        req_addr[32*w +: 32] = ~a;
        repeat ($urandom_range(2)) begin
            @(negedge clk);
            chk("ar_hold", {arvalid, araddr, arid}, {1'b1, a, 4'(w)});
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        chk("r_phase", {rready, arvalid}, 2'b10);
        exp_line = '0;
        exp_err = (nbeats - 1 != int'(len)) || nbeats > LB;
        for (int b = 0; b < nbeats; b++) begin
            if (b == abort) begin
                rvalid = 1'b0;
                resetn = 1'b0;
                req = '0;
                @(negedge clk);
                chk("rst_outs", {arvalid, rready, reload, rd_err, arid, araddr, arlen}, '0);
                chk("rst_line", line_data, '0);
                resetn = 1'b1;
                m_ptr = 0;
                @(negedge clk);
                chk("rst_no_reload", {reload, arvalid}, '0);
                return;
            end
            for (int g = 0; g < 3 && $urandom_range(3) == 0; g++) begin
                rvalid = 1'($urandom_range(1));
                rid = 4'(w) ^ 4'($urandom_range(15, 1));
                rdata = $urandom;
                rlast = 1'($urandom_range(1));
                rresp = 2'($urandom);
                @(negedge clk);
                chk("foreign_ignored", reload, '0);
            end
            if (dmode == 1) d = 32'(b);
            else if (dmode == 2) d = 32'h1234_5678;
            else d = $urandom;
            rvalid = 1'b1;
            rid = 4'(w);
            rdata = d;
            rresp = (b == bad) ? 2'b10 : 2'b00;
            rlast = (b == nbeats - 1);
            if (b < LB) exp_line[32*b +: 32] = d;
            if (b == bad) exp_err = 1'b1;
            @(negedge clk);
            if (b != nbeats - 1) chk("no_early_reload", reload, '0);
        end
        rvalid = 1'b0;
        rlast = 1'b0;
        chk("reload", reload, N'(1) << w);
        chk("rd_err", rd_err, exp_err);
        chk("line_data", line_data, exp_line);
        chk("rready_off", rready, 1'b0);
        if (!keep) req[w] = 1'b0;
        m_ptr = (w + 1) % N;
        @(negedge clk);
        chk("reload_one_cycle", {reload, rd_err}, '0);
        chk("line_hold", line_data, exp_line);
    endtask

    initial begin
        logic [N-1:0] m;
        logic [3:0] l;
        int nb, bd;
        repeat (2) @(negedge clk);
        chk("reset_outs", {arvalid, rready, reload, rd_err, arid, araddr, arlen}, '0);
        chk("reset_line", line_data, '0);
        resetn = 1'b1;
        txn(3'b100, 4'd0, 1, -1, 2, 1'b0, -1);
        txn(3'b001, 4'd15, 16, -1, 1, 1'b0, -1);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            l = 4'($urandom_range(3));
            txn(3'b111, l, int'(l) + 1, -1, 0, 1'b1, -1);
        end
        req = '0;
        txn(3'b010, 4'd7, 8, 3, 0, 1'b0, -1);
        txn(3'b010, 4'd7, 8, -1, 0, 1'b0, -1);
        txn(3'b001, 4'd7, 3, -1, 0, 1'b0, -1);
        txn(3'b100, 4'd15, 18, -1, 0, 1'b0, -1);
        txn(3'b010, 4'd7, 8, -1, 0, 1'b0, 4);
        txn(3'b010, 4'd7, 8, -1, 0, 1'b0, -1);
        for (int i = 0; i < 40; i++) begin
            m = N'($urandom_range(7, 1));
            l = 4'($urandom);
            nb = ($urandom_range(3) == 0) ? int'($urandom_range(17, 1)) : int'(l) + 1;
            bd = ($urandom_range(3) == 0) ? int'($urandom_range(nb - 1)) : -1;
            txn(m, l, nb, bd, 0, 1'($urandom_range(1)), -1);
            req = '0;
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
